// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port,
// synchronous-read data memory. One transaction is in flight at a time:
// grant in IDLE, one memory cycle in ACCESS, an optional READ capture
// cycle, then a held response in RESP until the owner consumes it.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  // requester 0: core load/store path
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_we,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [DATA_W-1:0] m0_req_wdata,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rsp_rdata,
  input  logic              m0_rsp_ready,
  // requester 1: program-loader/debug path
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_we,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [DATA_W-1:0] m1_req_wdata,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rsp_rdata,
  input  logic              m1_rsp_ready,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, READ, RESP} state_t;

  state_t            state;
  logic              prio;     // port preferred when both request
  logic              owner;    // port that owns the in-flight transaction
  logic [DATA_W-1:0] rdata_q;  // response data for the owner

  logic              any_valid;
  logic              grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              owner_rsp_ready;

  // Choose the grant candidate and mux its request fields.
  always_comb begin
    any_valid = m0_req_valid | m1_req_valid;
    // With a single requester it wins outright; with two, prio decides.
    if (m0_req_valid && m1_req_valid) grant = prio;
    else                              grant = m1_req_valid;
    sel_we          = grant ? m1_req_we    : m0_req_we;
    sel_addr        = grant ? m1_req_addr  : m0_req_addr;
    sel_wdata       = grant ? m1_req_wdata : m0_req_wdata;
    owner_rsp_ready = owner ? m1_rsp_ready : m0_rsp_ready;
  end

  // Ready is combinational in IDLE and forced low while reset is asserted,
  // so only the granted port ever sees it.
  assign m0_req_ready = reset_n && (state == IDLE) && m0_req_valid && !grant;
  assign m1_req_ready = reset_n && (state == IDLE) && m1_req_valid &&  grant;

  // Response data is visible only on the port holding a valid response.
  assign m0_rsp_rdata = m0_rsp_valid ? rdata_q : '0;
  assign m1_rsp_rdata = m1_rsp_valid ? rdata_q : '0;

  // Sequencer FSM with registered memory and response-valid outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      prio         <= 1'b0;
      owner        <= 1'b0;
      rdata_q      <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      m0_rsp_valid <= 1'b0;
      m1_rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            // Handshake edge: latch the request straight into the memory
            // drive registers so ACCESS presents it for exactly one cycle.
            owner     <= grant;
            prio      <= ~grant;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          if (mem_we) begin
            // Writes answer immediately with zero data.
            rdata_q <= '0;
            if (owner) m1_rsp_valid <= 1'b1;
            else       m0_rsp_valid <= 1'b1;
            state <= RESP;
          end else begin
            state <= READ;
          end
        end
        READ: begin
          rdata_q <= mem_rdata;
          if (owner) m1_rsp_valid <= 1'b1;
          else       m0_rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          if (owner_rsp_ready) begin
            m0_rsp_valid <= 1'b0;
            m1_rsp_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
